// File: rtl/dlx_mem_pkg.sv
// Shared encodings for the DLX fetch/data memory arbiter.
package dlx_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // Wide enough for any supported word; users size-cast down to DATA_WIDTH.
  localparam int                     ERR_RDATA_W = 64;
  localparam logic [ERR_RDATA_W-1:0] ERR_RDATA   = '1;

endpackage

// File: rtl/dlx_mem_arb_timer.sv
// Access timeout counter: counts ACCESS cycles without mem_ready.
module dlx_mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst || clr)
          cnt <= '0;
        else if (en)
          cnt <= cnt + CNT_W'(1);
      end

      // Fires in the cycle whose increment would reach the limit, so mem_req
      // stays high for exactly TIMEOUT_CYCLES cycles.
      assign expired = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Arbitrates one single-ported memory between DLX fetch and data stages.
//   state  | meaning
//   IDLE   | waiting; grants the winning pending request
//   ACCESS | mem_req held until mem_ready or timeout
//   DONE   | one-cycle valid pulse to the owner
module dlx_mem_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 20,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int STARVE_LIMIT    = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_rd_en,
  input  logic [INST_ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0]      inst_rdata,
  output logic                       inst_valid,
  input  logic                       data_rd_en,
  input  logic                       data_wr_en,
  input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]      data_wdata,
  output logic [DATA_WIDTH-1:0]      data_rdata,
  output logic                       data_valid,
  output logic                       mem_req,
  output logic                       mem_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  input  logic                       mem_ready,
  output logic                       pipe_stall,
  output logic                       bus_error
);

  localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  state_e            state, state_nxt;
  owner_e            owner;
  logic [SC_W-1:0]   starve_cnt;
  logic              data_req, fetch_first;
  logic              grant_inst, grant_data, access_end, expired;

  assign data_req    = data_rd_en | data_wr_en;
  assign fetch_first = (STARVE_LIMIT != 0) && (starve_cnt == SC_W'(STARVE_LIMIT));

  always_comb begin
    state_nxt  = state;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    access_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (inst_rd_en && (!data_req || fetch_first))
          grant_inst = 1'b1;
        else if (data_req)
          grant_data = 1'b1;
        if (grant_inst || grant_data)
          state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (mem_ready || expired) begin
          access_end = 1'b1;
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  dlx_mem_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_inst | grant_data),
    .en      ((state == ST_ACCESS) && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWNER_INST;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
      bus_error  <= 1'b0;
      if (grant_inst) begin
        owner      <= OWNER_INST;
        mem_req    <= 1'b1;
        mem_wr_en  <= 1'b0;
        mem_addr   <= MEM_ADDR_WIDTH'(inst_addr);
        mem_wdata  <= '0;
        starve_cnt <= '0;
      end
      if (grant_data) begin
        owner     <= OWNER_DATA;
        mem_req   <= 1'b1;
        mem_wr_en <= data_wr_en;
        mem_addr  <= MEM_ADDR_WIDTH'(data_addr);
        mem_wdata <= data_wdata;
        if (inst_rd_en && (starve_cnt != SC_W'(STARVE_LIMIT)))
          starve_cnt <= starve_cnt + SC_W'(1);
      end
      if (access_end) begin
        mem_req   <= 1'b0;
        bus_error <= !mem_ready;
        if (owner == OWNER_INST) begin
          inst_valid <= 1'b1;
          inst_rdata <= mem_ready ? mem_rdata : DATA_WIDTH'(ERR_RDATA);
        end else begin
          data_valid <= 1'b1;
          // Stores leave the load-data register untouched.
          if (!mem_wr_en)
            data_rdata <= mem_ready ? mem_rdata : DATA_WIDTH'(ERR_RDATA);
        end
      end
    end
  end

  assign pipe_stall = (inst_rd_en & ~inst_valid) | (data_req & ~data_valid);

endmodule

// File: doc/dlx_mem_arbiter.md
# dlx_mem_arbiter

Shares one single-ported memory between the DLX fetch stage and the data-memory stage. It arbitrates each access, drives the memory handshake, and returns read data and a completion pulse to the owning requester. It also raises a pipeline stall while any request is outstanding and aborts accesses the memory never acknowledges. It sits between the processor's instruction/data ports and the unified memory interface.

## Interface
- DATA_WIDTH, 32, data and instruction word width
- INST_ADDR_WIDTH, 20, fetch address width
- DATA_ADDR_WIDTH, 32, data address width
- MEM_ADDR_WIDTH, 32, memory address width
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; 0 = pure data priority
- TIMEOUT_CYCLES, 255, ACCESS cycles before abort; 0 = never abort
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- inst_rd_en  in  1  fetch request, held until inst_valid
- inst_addr  in  INST_ADDR_WIDTH  fetch address
- inst_rdata  out  DATA_WIDTH  fetched word, valid with inst_valid
- inst_valid  out  1  one-cycle completion pulse for fetch
- data_rd_en  in  1  data read request
- data_wr_en  in  1  data write request; wins if both are high
- data_addr  in  DATA_ADDR_WIDTH  data address
- data_wdata  in  DATA_WIDTH  store data
- data_rdata  out  DATA_WIDTH  load data, valid with data_valid
- data_valid  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory request, registered
- mem_wr_en  out  1  write qualifier for mem_req
- mem_addr  out  MEM_ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, sampled when mem_ready is high
- mem_ready  in  1  memory acknowledge
- pipe_stall  out  1  a request is pending and has not completed
- bus_error  out  1  one-cycle pulse on timeout abort

## Operation
- FSM states:
  - IDLE: accepts requests; if any is pending, latches owner, address, write flag and wdata, then goes to ACCESS.
  - ACCESS: holds mem_req. On mem_ready it captures mem_rdata (reads only) and goes to DONE. On timeout it goes to DONE with the error flag set.
  - DONE: pulses the owner's valid for one cycle, then returns to IDLE.
- Priority in IDLE:
  - Data wins by default.
  - Fetch wins if both requests are pending and starve_cnt == STARVE_LIMIT (STARVE_LIMIT != 0).
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each data grant made while inst_rd_en is high.
  - Clears on each fetch grant.
- Requester protocol:
  - A requester holds its enable, address and wdata stable until its valid pulse, then deasserts in the valid cycle.
  - IDLE following DONE therefore never re-serves the same request.
  - A request dropped before grant is ignored.
  - A request dropped after grant still completes and pulses valid.
- Address widths: inst_addr is zero-extended to MEM_ADDR_WIDTH; data_addr supplies its low MEM_ADDR_WIDTH bits.
- Timeout:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
  - At TIMEOUT_CYCLES it drops mem_req and goes to DONE.
  - In that DONE, valid and bus_error are high together, and the owner's rdata is all ones (reads).
  - Writes complete with no data effect guaranteed.
- Writes: the valid pulse only signals completion; the rdata registers hold their previous values.
- pipe_stall = (inst_rd_en & ~inst_valid) | ((data_rd_en | data_wr_en) & ~data_valid), combinational.

## Timing
- Reset values: state IDLE, mem_req 0, mem_wr_en 0, mem_addr 0, mem_wdata 0, both rdata 0, both valid 0, bus_error 0, starve_cnt 0, timeout counter 0.
- Reset in the middle of an access abandons it: mem_req is low the cycle after rst and no valid pulse is produced.
- Request seen in IDLE at cycle 0:
  - mem_req/mem_addr valid from cycle 1.
  - With mem_ready high in cycle 1, valid and rdata appear in cycle 2.
  - IDLE in cycle 3.
- Zero-wait throughput is one access per 3 cycles; each wait cycle adds one.
- mem_req, mem_wr_en, mem_addr and mem_wdata are constant throughout ACCESS.
- mem_ready outside ACCESS is ignored.
- Timeout with TIMEOUT_CYCLES = N: mem_req is high for exactly N cycles, then valid and bus_error pulse in the next cycle.

## Structure
- Shared package dlx_mem_pkg holds:
  - state encoding (IDLE/ACCESS/DONE)
  - owner encoding (OWNER_INST/OWNER_DATA)
  - ERR_RDATA constant (all ones)
- One sub-module: dlx_mem_arb_timer.
  - Timeout counter with clear/enable inputs and an expired output.
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - It is disabled when TIMEOUT_CYCLES = 0.
- FSM, priority logic and starve_cnt live in dlx_mem_arbiter.

## Test plan
- Fetch read of 0x40000, mem_ready high in the first ACCESS cycle, mem_rdata 0x20010005 -> mem_addr 0x00040000 in cycle 1, inst_valid with inst_rdata 0x20010005 in cycle 2, pipe_stall low in cycle 2.
- Data write 0x1234 to address 0x100 plus a simultaneous fetch -> data is served first (mem_wr_en=1, mem_wdata=0x1234), fetch is served next, data_rdata is unchanged.
- STARVE_LIMIT=4, continuous data requests plus a held fetch -> grant order D,D,D,D,I,D…
- TIMEOUT_CYCLES=8, load with mem_ready never high -> mem_req high for 8 cycles, then data_valid and bus_error pulse together with data_rdata 0xFFFFFFFF.
- rst asserted in the 2nd ACCESS cycle of a fetch -> mem_req is 0 the next cycle, no inst_valid, and a new request restarts from IDLE.
- Fetch request dropped while data owns ACCESS -> no fetch grant and no inst_valid.
